// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: issue-side scoreboard and write-back port scheduler for the
// core register file. Each cycle it decides whether one instruction may issue,
// checking RAW/WAW hazards on GPRs and write-port availability in the target
// retirement cycle. It then reserves a write port and drives the RF write
// enables and selects when that instruction retires.
//
// Ports:
//   clk_i, rst_i (sync, active-high), flush_i (same effect as reset)
//   issue_valid_i / issue_ready_o   - issue handshake; ready is combinational
//   issue_src_i / issue_src_en_i    - three source addresses, each with an enable
//   issue_dst_i / issue_dst_en_i    - destination address and its write enable
//   issue_lat_i                     - result latency; 0 is treated as 1, and
//                                     values above MAX_LAT are clamped to MAX_LAT
//   wb_port_o                       - write port given to the accepted instruction
//                                     (combinational)
//   illegal_dst_o                   - one-cycle pulse when an accepted instruction
//                                     targets a read-only address
//   wr_en_o / wr_sel_o              - RF enable_writing_i / select_r_i
//   busy_o                          - per-GPR pending-write mask
module rf_wb_scheduler #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned MAX_LAT       = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                flush_i,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  logic [3*ADDRESS_WIDTH-1:0]          issue_src_i,
  input  logic [2:0]                          issue_src_en_i,
  input  logic [ADDRESS_WIDTH-1:0]            issue_dst_i,
  input  logic                                issue_dst_en_i,
  input  logic [$clog2(MAX_LAT+1)-1:0]        issue_lat_i,
  output logic [1:0]                          wb_port_o,
  output logic                                illegal_dst_o,
  output logic [3:0]                          wr_en_o,
  output logic [4*ADDRESS_WIDTH-1:0]          wr_sel_o,
  output logic [2**ADDRESS_WIDTH-3:0]         busy_o
);

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned NUM_GPR   = 2**ADDRESS_WIDTH - 2;
  localparam int unsigned LAT_WIDTH = $clog2(MAX_LAT+1);

  // Write-back pipeline; stage k retires k cycles from now, stage 1 drives the RF.
  logic [NUM_PORTS-1:0]                        stg_vld_q  [1:MAX_LAT];
  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]     stg_addr_q [1:MAX_LAT];
  logic [NUM_PORTS-1:0]                        stg_vld_d  [1:MAX_LAT];
  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0]     stg_addr_d [1:MAX_LAT];

  logic [NUM_GPR-1:0] busy_q, busy_d;
  logic               illegal_q;

  logic [LAT_WIDTH-1:0] lat_n;
  logic                 dst_gpr;
  logic                 eff_wr;
  logic                 src_hazard;
  logic                 dst_busy;
  logic [NUM_PORTS-1:0] tgt_vld;
  logic                 port_free;
  logic [1:0]           port_sel;
  logic                 accept;

  // Normalise the requested latency into the range 1..MAX_LAT.
  always_comb begin
    lat_n = issue_lat_i;
    if (issue_lat_i == '0) begin
      lat_n = LAT_WIDTH'(1);
    end else if (issue_lat_i > LAT_WIDTH'(MAX_LAT)) begin
      lat_n = LAT_WIDTH'(MAX_LAT);
    end
  end

  assign dst_gpr = (issue_dst_i < ADDRESS_WIDTH'(NUM_GPR));
  assign eff_wr  = issue_dst_en_i & dst_gpr;

  // Hazard lookup; read-only addresses never match a GPR index.
  always_comb begin
    src_hazard = 1'b0;
    dst_busy   = 1'b0;
    for (int g = 0; g < int'(NUM_GPR); g++) begin
      for (int s = 0; s < 3; s++) begin
        if (issue_src_en_i[s] && busy_q[g] &&
            (issue_src_i[s*ADDRESS_WIDTH +: ADDRESS_WIDTH] == ADDRESS_WIDTH'(g))) begin
          src_hazard = 1'b1;
        end
      end
      if (busy_q[g] && (issue_dst_i == ADDRESS_WIDTH'(g))) begin
        dst_busy = 1'b1;
      end
    end
  end

  // S[L+1] becomes S[L] at the next edge; S[MAX_LAT+1] is always empty.
  always_comb begin
    tgt_vld = '0;
    for (int k = 2; k <= int'(MAX_LAT); k++) begin
      if (int'(lat_n) + 1 == k) begin
        tgt_vld = stg_vld_q[k];
      end
    end
  end

  assign port_free = ~(&tgt_vld);

  // Lowest free port of the target stage.
  always_comb begin
    port_sel = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (!tgt_vld[p]) begin
        port_sel = 2'(p);
      end
    end
  end

  assign issue_ready_o = ~rst_i & ~flush_i & ~src_hazard &
                         (~eff_wr | (~dst_busy & port_free));
  assign accept        = issue_valid_i & issue_ready_o;
  assign wb_port_o     = eff_wr ? port_sel : 2'd0;

  // Next state: shift the pipeline, retire stage 1, insert the new reservation.
  always_comb begin
    for (int k = 1; k < int'(MAX_LAT); k++) begin
      stg_vld_d[k]  = stg_vld_q[k+1];
      stg_addr_d[k] = stg_addr_q[k+1];
    end
    stg_vld_d[MAX_LAT]  = '0;
    stg_addr_d[MAX_LAT] = '0;
    busy_d              = busy_q;

    for (int p = 0; p < int'(NUM_PORTS); p++) begin
      for (int g = 0; g < int'(NUM_GPR); g++) begin
        if (stg_vld_q[1][p] && (stg_addr_q[1][p] == ADDRESS_WIDTH'(g))) begin
          busy_d[g] = 1'b0;
        end
      end
    end

    if (accept && eff_wr) begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        if (k == int'(lat_n)) begin
          stg_vld_d[k][port_sel]  = 1'b1;
          stg_addr_d[k][port_sel] = issue_dst_i;
        end
      end
      for (int g = 0; g < int'(NUM_GPR); g++) begin
        if (issue_dst_i == ADDRESS_WIDTH'(g)) begin
          busy_d[g] = 1'b1;
        end
      end
    end
  end

  // State registers; flush drops all pending writes exactly like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        stg_vld_q[k]  <= '0;
        stg_addr_q[k] <= '0;
      end
      busy_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      for (int k = 1; k <= int'(MAX_LAT); k++) begin
        stg_vld_q[k]  <= stg_vld_d[k];
        stg_addr_q[k] <= stg_addr_d[k];
      end
      busy_q    <= busy_d;
      illegal_q <= accept & issue_dst_en_i & ~dst_gpr;
    end
  end

  assign wr_en_o       = stg_vld_q[1];
  assign wr_sel_o      = stg_addr_q[1];
  assign busy_o        = busy_q;
  assign illegal_dst_o = illegal_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed testbench for rf_wb_scheduler with default parameters.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
module tb_rf_wb_scheduler;

  localparam int unsigned AW = 4;
  localparam int unsigned ML = 8;
  localparam int unsigned LW = $clog2(ML+1);

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            issue_valid_i;
  logic            issue_ready_o;
  logic [3*AW-1:0] issue_src_i;
  logic [2:0]      issue_src_en_i;
  logic [AW-1:0]   issue_dst_i;
  logic            issue_dst_en_i;
  logic [LW-1:0]   issue_lat_i;
  logic [1:0]      wb_port_o;
  logic            illegal_dst_o;
  logic [3:0]      wr_en_o;
  logic [4*AW-1:0] wr_sel_o;
  logic [2**AW-3:0] busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  rf_wb_scheduler #(.ADDRESS_WIDTH(AW), .MAX_LAT(ML)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_src_i    (issue_src_i),
    .issue_src_en_i (issue_src_en_i),
    .issue_dst_i    (issue_dst_i),
    .issue_dst_en_i (issue_dst_en_i),
    .issue_lat_i    (issue_lat_i),
    .wb_port_o      (wb_port_o),
    .illegal_dst_o  (illegal_dst_o),
    .wr_en_o        (wr_en_o),
    .wr_sel_o       (wr_sel_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] dst, input logic den,
                       input logic [3:0] lat, input logic [2:0] sen, input logic [11:0] src);
    issue_valid_i  = v;
    issue_dst_i    = dst;
    issue_dst_en_i = den;
    issue_lat_i    = lat;
    issue_src_en_i = sen;
    issue_src_i    = src;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 3'b000, 12'h000);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    idle();
    next_cycle();
    mid(); check("rst_ready", 32'(issue_ready_o), 32'd0);
    next_cycle();
    rst_i = 1'b0;
    mid();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_wren", 32'(wr_en_o), 32'd0);
    check("rst_illegal", 32'(illegal_dst_o), 32'd0);
    check("rst_ready_after", 32'(issue_ready_o), 32'd1);
    next_cycle();

    // Basic: dst=3, L=2
    drive(1'b1, 4'd3, 1'b1, 4'd2, 3'b000, 12'h000);
    mid(); check("a_ready", 32'(issue_ready_o), 32'd1); check("a_port", 32'(wb_port_o), 32'd0);
    next_cycle(); idle();
    mid(); check("a_busy_t1", 32'(busy_o[3]), 32'd1); check("a_wren_t1", 32'(wr_en_o), 32'd0);
    next_cycle();
    mid(); check("a_busy_t2", 32'(busy_o[3]), 32'd1); check("a_wren_t2", 32'(wr_en_o), 32'd1);
    check("a_sel_t2", 32'(wr_sel_o[3:0]), 32'd3);
    next_cycle();
    mid(); check("a_wren_t3", 32'(wr_en_o), 32'd0); check("a_busy_t3", 32'(busy_o), 32'd0);
    next_cycle();

    // RAW: dst=5 L=3, then a consumer of r5
    drive(1'b1, 4'd5, 1'b1, 4'd3, 3'b000, 12'h000);
    mid(); check("raw_prod_ready", 32'(issue_ready_o), 32'd1);
    next_cycle();
    drive(1'b1, 4'd0, 1'b0, 4'd1, 3'b001, 12'h005);
    for (int i = 1; i <= 3; i++) begin
      mid(); check("raw_stall", 32'(issue_ready_o), 32'd0);
      next_cycle();
    end
    mid(); check("raw_go", 32'(issue_ready_o), 32'd1);
    next_cycle(); idle();

    // Port exhaustion: four writes retiring together, a fifth stalls one cycle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(i+1), 1'b1, 4'(5-i), 3'b000, 12'h000);
      mid(); check("px_ready", 32'(issue_ready_o), 32'd1); check("px_port", 32'(wb_port_o), 32'(i));
      next_cycle();
    end
    drive(1'b1, 4'd6, 1'b1, 4'd1, 3'b000, 12'h000);
    mid(); check("px_stall", 32'(issue_ready_o), 32'd0); check("px_busy", 32'(busy_o), 32'h1E);
    next_cycle();
    mid(); check("px_wren_all", 32'(wr_en_o), 32'hF); check("px_sel_all", 32'(wr_sel_o), 32'h4321);
    check("px_fifth_ready", 32'(issue_ready_o), 32'd1); check("px_fifth_port", 32'(wb_port_o), 32'd0);
    next_cycle(); idle();
    mid(); check("px_fifth_wren", 32'(wr_en_o), 32'd1); check("px_fifth_sel", 32'(wr_sel_o[3:0]), 32'd6);
    check("px_fifth_busy", 32'(busy_o), 32'h40);
    next_cycle();
    mid(); check("px_drain_wren", 32'(wr_en_o), 32'd0); check("px_drain_busy", 32'(busy_o), 32'd0);
    next_cycle();

    // Read-only sources never stall, even with a busy GPR
    drive(1'b1, 4'd0, 1'b1, 4'd8, 3'b000, 12'h000);
    mid(); check("ro_prod_ready", 32'(issue_ready_o), 32'd1);
    next_cycle();
    drive(1'b1, 4'd0, 1'b0, 4'd1, 3'b011, {4'd0, 4'd15, 4'd14});
    mid(); check("ro_src", 32'(issue_ready_o), 32'd1);
    next_cycle();
    drive(1'b1, 4'd0, 1'b0, 4'd1, 3'b111, {4'd0, 4'd15, 4'd14});
    mid(); check("ro_src_hazard", 32'(issue_ready_o), 32'd0);
    next_cycle(); idle();
    repeat (8) next_cycle();

    // Read-only destination: accepted, flagged, never written
    drive(1'b1, 4'd15, 1'b1, 4'd2, 3'b000, 12'h000);
    mid(); check("ill_ready", 32'(issue_ready_o), 32'd1); check("ill_port", 32'(wb_port_o), 32'd0);
    next_cycle(); idle();
    mid(); check("ill_pulse", 32'(illegal_dst_o), 32'd1); check("ill_busy", 32'(busy_o), 32'd0);
    check("ill_wren1", 32'(wr_en_o), 32'd0);
    next_cycle();
    mid(); check("ill_pulse_end", 32'(illegal_dst_o), 32'd0); check("ill_wren2", 32'(wr_en_o), 32'd0);
    next_cycle();
    mid(); check("ill_wren3", 32'(wr_en_o), 32'd0);
    next_cycle();

    // L=0 behaves as L=1
    drive(1'b1, 4'd9, 1'b1, 4'd0, 3'b000, 12'h000);
    mid(); check("l0_ready", 32'(issue_ready_o), 32'd1); check("l0_port", 32'(wb_port_o), 32'd0);
    next_cycle(); idle();
    mid(); check("l0_wren", 32'(wr_en_o), 32'd1); check("l0_sel", 32'(wr_sel_o[3:0]), 32'd9);
    check("l0_busy", 32'(busy_o), 32'h200);
    next_cycle();
    mid(); check("l0_wren_end", 32'(wr_en_o), 32'd0); check("l0_busy_end", 32'(busy_o), 32'd0);
    next_cycle();

    // L=15 clamps to MAX_LAT=8
    drive(1'b1, 4'd10, 1'b1, 4'd15, 3'b000, 12'h000);
    mid(); check("clamp_ready", 32'(issue_ready_o), 32'd1);
    next_cycle(); idle();
    repeat (6) next_cycle();
    mid(); check("clamp_wren_t7", 32'(wr_en_o), 32'd0);
    next_cycle();
    mid(); check("clamp_wren_t8", 32'(wr_en_o), 32'd1); check("clamp_sel_t8", 32'(wr_sel_o[3:0]), 32'hA);
    next_cycle();

    // WAW: dst=7 L=8, then dst=7 L=1 stalls until t+9
    drive(1'b1, 4'd7, 1'b1, 4'd8, 3'b000, 12'h000);
    mid(); check("waw_first_ready", 32'(issue_ready_o), 32'd1);
    next_cycle();
    drive(1'b1, 4'd7, 1'b1, 4'd1, 3'b000, 12'h000);
    for (int i = 1; i <= 8; i++) begin
      mid(); check("waw_stall", 32'(issue_ready_o), 32'd0);
      if (i == 8) begin
        check("waw_first_wren", 32'(wr_en_o), 32'd1);
        check("waw_first_sel", 32'(wr_sel_o[3:0]), 32'd7);
      end
      next_cycle();
    end
    mid(); check("waw_go", 32'(issue_ready_o), 32'd1); check("waw_port", 32'(wb_port_o), 32'd0);
    next_cycle(); idle();
    mid(); check("waw_second_wren", 32'(wr_en_o), 32'd1); check("waw_second_sel", 32'(wr_sel_o[3:0]), 32'd7);
    next_cycle();
    mid(); check("waw_done_busy", 32'(busy_o), 32'd0);
    next_cycle();

    // Flush with three pending writes
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(i+1), 1'b1, 4'd5, 3'b000, 12'h000);
      mid(); check("fl_issue_port", 32'(wb_port_o), 32'd0);
      next_cycle();
    end
    idle();
    flush_i = 1'b1;
    mid(); check("fl_ready_during", 32'(issue_ready_o), 32'd0); check("fl_busy_before", 32'(busy_o), 32'h0E);
    next_cycle();
    flush_i = 1'b0;
    mid(); check("fl_busy_after", 32'(busy_o), 32'd0); check("fl_wren_after", 32'(wr_en_o), 32'd0);
    check("fl_ready_after", 32'(issue_ready_o), 32'd1);
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      mid(); check("fl_no_wren", 32'(wr_en_o), 32'd0);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
